// File: rtl/frame_pingpong_buffer_if.sv
// Handshake and frame-announce signals between acquisition, the ping-pong
// frame buffer and the UDP sender.
interface frame_pingpong_buffer_if #(
    parameter int unsigned DW = 32
);
    logic [DW-1:0] i_in_data;
    logic          i_in_vld;
    logic          i_in_last;
    logic          o_in_rdy;
    logic [DW-1:0] o_out_data;
    logic          o_out_vld;
    logic          o_out_last;
    logic          i_out_rdy;
    logic          o_frame_ready;
    logic [15:0]   o_frame_size;
    logic          o_trunc;

    modport master (
        output i_in_data, i_in_vld, i_in_last, i_out_rdy,
        input  o_in_rdy, o_out_data, o_out_vld, o_out_last,
               o_frame_ready, o_frame_size, o_trunc
    );

    modport slave (
        input  i_in_data, i_in_vld, i_in_last, i_out_rdy,
        output o_in_rdy, o_out_data, o_out_vld, o_out_last,
               o_frame_ready, o_frame_size, o_trunc
    );
endinterface

// File: rtl/frame_pingpong_buffer.sv
// Two-bank frame store: acquisition fills one bank while the sender drains the
// other; each completed frame is announced with its word count, then replayed.
module frame_pingpong_buffer #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10,
    parameter int unsigned DW    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    frame_pingpong_buffer_if.slave bus
);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_READING} bank_e;
    typedef enum logic [1:0] {R_IDLE, R_ANNOUNCE, R_STREAM} rd_state_e;

    logic [DW-1:0] mem [0:1][0:DEPTH-1];

    bank_e         bank_st  [2];
    bank_e         bank_nxt [2];
    logic [CW-1:0] bank_cnt [2];

    logic          wr_bank;
    logic [AW-1:0] wr_addr;
    logic          in_rdy;
    logic          trunc;

    rd_state_e     rd_state;
    logic          rd_bank;
    logic [CW-1:0] rd_addr;
    logic [CW-1:0] rd_cnt;
    logic [DW-1:0] rd_q;
    logic          rd_vld;
    logic          rd_last;

    logic [DW-1:0] out_data;
    logic          out_vld;
    logic          out_last;
    logic [DW-1:0] skid_data;
    logic          skid_vld;
    logic          skid_last;
    logic          frame_ready;
    logic [15:0]   frame_size;

    logic          wr_acc;
    logic          wr_close;
    logic          nxt_wr_bank;
    logic          in_rdy_nxt;
    logic          pop;
    logic          rd_start;
    logic          rd_free;
    logic          rd_issue;
    logic [2:0]    occ_after;

    // Bank transitions from both sides; writer and reader never touch a bank in the same state
    always_comb begin
        wr_acc      = bus.i_in_vld & in_rdy;
        wr_close    = wr_acc & (bus.i_in_last | (wr_addr == AW'(DEPTH - 1)));
        pop         = out_vld & bus.i_out_rdy;
        rd_start    = (rd_state == R_IDLE) & (bank_st[rd_bank] == B_FULL);
        rd_free     = (rd_state == R_STREAM) & pop & out_last;
        // Words held or arriving after this edge; a new read may only be issued if one slot stays free
        occ_after   = 3'(out_vld) + 3'(skid_vld) + 3'(rd_vld) - 3'(pop);
        rd_issue    = (rd_state != R_IDLE) & (rd_addr < rd_cnt) & (occ_after <= 3'd1);
        bank_nxt[0] = bank_st[0];
        bank_nxt[1] = bank_st[1];
        if (wr_acc) begin
            bank_nxt[wr_bank] = wr_close ? B_FULL : B_FILLING;
        end
        if (rd_start) begin
            bank_nxt[rd_bank] = B_READING;
        end
        if (rd_free) begin
            bank_nxt[rd_bank] = B_EMPTY;
        end
        nxt_wr_bank = wr_close ? ~wr_bank : wr_bank;
        in_rdy_nxt  = (bank_nxt[nxt_wr_bank] == B_EMPTY) | (bank_nxt[nxt_wr_bank] == B_FILLING);
    end

    // Write side and bank bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                bank_st[i]  <= B_EMPTY;
                bank_cnt[i] <= '0;
            end
            wr_bank <= 1'b0;
            wr_addr <= '0;
            in_rdy  <= 1'b0;
            trunc   <= 1'b0;
        end else begin
            bank_st[0] <= bank_nxt[0];
            bank_st[1] <= bank_nxt[1];
            in_rdy     <= in_rdy_nxt;
            trunc      <= wr_close & ~bus.i_in_last;
            if (wr_acc) begin
                if (wr_close) begin
                    bank_cnt[wr_bank] <= CW'(wr_addr) + CW'(1);
                    wr_addr           <= '0;
                    wr_bank           <= ~wr_bank;
                end else begin
                    wr_addr <= wr_addr + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_bank][wr_addr] <= bus.i_in_data;
        end
        if (rd_issue) begin
            rd_q <= mem[rd_bank][rd_addr[AW-1:0]];
        end
    end

    // Read FSM, RAM prefetch and 2-entry output skid stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state    <= R_IDLE;
            rd_bank     <= 1'b0;
            rd_addr     <= '0;
            rd_cnt      <= '0;
            rd_vld      <= 1'b0;
            rd_last     <= 1'b0;
            out_data    <= '0;
            out_vld     <= 1'b0;
            out_last    <= 1'b0;
            skid_data   <= '0;
            skid_vld    <= 1'b0;
            skid_last   <= 1'b0;
            frame_ready <= 1'b0;
            frame_size  <= '0;
        end else begin
            frame_ready <= 1'b0;
            rd_vld      <= rd_issue;
            if (rd_issue) begin
                rd_last <= (rd_addr == rd_cnt - CW'(1));
                rd_addr <= rd_addr + CW'(1);
            end
            case (rd_state)
                R_IDLE: begin
                    if (rd_start) begin
                        rd_state    <= R_ANNOUNCE;
                        frame_ready <= 1'b1;
                        frame_size  <= 16'(bank_cnt[rd_bank]);
                        rd_cnt      <= bank_cnt[rd_bank];
                        rd_addr     <= '0;
                    end
                end
                R_ANNOUNCE: rd_state <= R_STREAM;
                R_STREAM: begin
                    if (rd_free) begin
                        rd_state <= R_IDLE;
                        rd_bank  <= ~rd_bank;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase

            if (pop) begin
                if (skid_vld) begin
                    out_data <= skid_data;
                    out_last <= skid_last;
                    out_vld  <= 1'b1;
                end else begin
                    out_data <= rd_q;
                    out_last <= rd_vld & rd_last;
                    out_vld  <= rd_vld;
                end
                skid_vld <= skid_vld & rd_vld;
                if (skid_vld & rd_vld) begin
                    skid_data <= rd_q;
                    skid_last <= rd_last;
                end
            end else if (!out_vld) begin
                out_data <= rd_q;
                out_last <= rd_vld & rd_last;
                out_vld  <= rd_vld;
            end else if (rd_vld) begin
                skid_data <= rd_q;
                skid_last <= rd_last;
                skid_vld  <= 1'b1;
            end
        end
    end

    assign bus.o_in_rdy      = in_rdy;
    assign bus.o_out_data    = out_data;
    assign bus.o_out_vld     = out_vld;
    assign bus.o_out_last    = out_last;
    assign bus.o_frame_ready = frame_ready;
    assign bus.o_frame_size  = frame_size;
    assign bus.o_trunc       = trunc;

endmodule

// File: doc/frame_pingpong_buffer.md
Name: frame_pingpong_buffer

Overview:
- Double-buffered (ping-pong) frame store between the acquisition core's 32-bit sample stream and the UDP packet sender.
- Collects one complete frame per bank, then announces it with a one-cycle frame-ready pulse and a word count.
- Replays the frame on a valid/ready stream, so the sender's announced UDP length always matches the data that follows.
- Runs in the sys_clk domain; acquisition fills one bank while the sender drains the other.

Parameters:
- DEPTH, 1024, words per bank; power of two, 4..8192.
- AW, 10, bank address width; must equal log2(DEPTH).
- DW, 32, data word width.

Ports:
- clk  in  1  system clock (sys_clk domain).
- rst_n  in  1  asynchronous active-low reset.
- i_in_data  in  DW  frame word from acquisition.
- i_in_vld  in  1  i_in_data valid.
- i_in_last  in  1  qualifies the accepted word as the last word of the frame.
- o_in_rdy  out  1  buffer can accept a word.
- o_out_data  out  DW  frame word to sender.
- o_out_vld  out  1  o_out_data valid.
- o_out_last  out  1  marks the final word of the frame being read.
- i_out_rdy  in  1  sender accepts a word.
- o_frame_ready  out  1  one-cycle pulse: a frame is ready and readout begins.
- o_frame_size  out  16  word count of the current/last announced frame.
- o_trunc  out  1  one-cycle pulse: frame force-closed at DEPTH words.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n). All state is cleared on rst_n low, independent of clk.
- Reset values: o_in_rdy=0 during reset and 1 in the first cycle after release; o_out_vld=0, o_out_last=0, o_frame_ready=0, o_trunc=0, o_frame_size=0. Both banks EMPTY, write bank=0, read bank=0.
- Bank states: EMPTY -> FILLING -> FULL -> READING -> EMPTY. Each bank stores its own word count (AW+1 bits).
- Write side:
  - A word is accepted when i_in_vld & o_in_rdy.
  - It is written at the current write address, and the address increments.
  - o_in_rdy=1 iff the write bank is EMPTY or FILLING.
- Frame close:
  - Condition: an accepted word with i_in_last=1, or the DEPTH-th accepted word.
  - On close, the bank goes FULL with count = words written (1..DEPTH), and the write pointer moves to the other bank.
  - If the other bank is not EMPTY, o_in_rdy drops the next cycle and stays low until that bank is freed. There is no data loss and no overwrite.
- Truncation: if the DEPTH-th word arrives without i_in_last, o_trunc pulses in the following cycle. The next accepted word starts a new frame.
- Empty frames: none exist; the minimum frame is 1 word, because i_in_last only qualifies an accepted word.
- Read side (FSM R_IDLE, R_ANNOUNCE, R_STREAM):
  - R_IDLE: when the read bank is FULL, go to R_ANNOUNCE. Frames are read in completion order; the banks alternate.
  - R_ANNOUNCE (1 cycle): o_frame_ready=1; o_frame_size = {zero-extend count to 16 bits}. The bank goes READING.
  - R_STREAM: the RAM read is synchronous with 1-cycle latency. The first o_out_vld is asserted exactly 2 cycles after the o_frame_ready cycle.
- Stream rules:
  - Data, last and vld hold steady while o_out_vld & !i_out_rdy.
  - Throughput is 1 word/cycle with no bubbles while i_out_rdy=1. This requires a 2-entry output skid stage or a prefetch.
  - o_out_last=1 only on word count-1.
- End of readout: on acceptance of the last word, the bank goes EMPTY (usable by the writer the next cycle), the read pointer toggles, and the FSM returns to R_IDLE. The next frame_ready can occur no earlier than 1 cycle after the last accept.
- o_frame_size: stable from the announce cycle until the next announce. The sender multiplies it by 4 to get the byte length.
- Simultaneous events:
  - Writer closing a bank in the same cycle the reader frees the other: both transitions take effect, and o_in_rdy stays 1.
  - Write and read on different banks in the same cycle: always legal.
- Reset mid-operation: any partial or full frames are discarded, and the output stream is cut without asserting o_out_last. The downstream sender must also be reset.

Test Plan:
- Single frame: 8 words 0x100..0x107, last on 0x107, i_out_rdy=1 -> o_frame_ready pulse with size=8; data 0x100..0x107 on 8 consecutive cycles starting 2 cycles after the pulse; o_out_last on 0x107.
- Back-pressure: same frame with i_out_rdy toggling 1,0,0,1,... -> no word lost or duplicated; data stable while stalled; order preserved.
- Ping-pong full: i_out_rdy=0; write frames A (4 words), B (5 words), then start C -> o_in_rdy=0 after B closes. Release i_out_rdy -> A read with size=4, o_in_rdy=1 one cycle after A's last accept, then B with size=5.
- Truncation, DEPTH=16: 20 words with no last -> o_trunc pulse; first frame size=16; words 17..20 form a second frame ending at the next i_in_last.
- Minimum frame: a single word with i_in_last=1 -> size=1; one o_out_vld cycle with o_out_last=1.
- Reset mid-stream: assert rst_n=0 during word 3 of readout -> all outputs go to reset values asynchronously; a fresh 2-word frame after release reads correctly with size=2.
